dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int DEPTH_LOG2_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide RAM, 2^DEPTH_LOG2 x WORD_W, synchronous write and combinational read.
// Latency: write lands on the clock edge; read data follows addr combinationally.
// Backpressure: none, the array accepts a write on every cycle we=1.
//
// Ports: clk (clock), we (write enable), addr (word index),
//        wdata (write word), rdata (read word at addr).
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [1<<DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Latency: request accepted at edge T gives rsp_valid from edge T+1+WAIT_CYCLES.
// Backpressure: req_ready low while busy; response held stable until rsp_ready.
//
// Ports: clk, reset (synchronous, active-high);
//        req_valid/req_ready/req_we/req_addr/req_wdata (request channel);
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err (response channel); busy.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag (and suppress)
// accesses whose byte address is not word aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state;
  logic [3:0]            wait_cnt;

  logic                  cap_we;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [WORD_W-1:0]     cap_wdata;
  logic                  acc_err;

  logic                  mem_we;
  logic [WORD_W-1:0]     mem_rdata;

  wire accept = (state == IDLE) && req_valid && req_ready;

  // Captured request; no reset needed, only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_idx   <= req_addr[DEPTH_LOG2+1:2];
      cap_wdata <= req_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic cap_misalign;

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_misalign <= (req_addr[1:0] != 2'b00);
    end
  end

  assign acc_err = cap_misalign;
`else
  assign acc_err = 1'b0;
`endif

  // The first RESP cycle (rsp_valid still low) is the single access slot.
  // Gating with reset keeps a reset on that very edge from committing.
  assign mem_we = (state == RESP) && !rsp_valid && cap_we && !acc_err && !reset;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_INIT == 4'd0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= RESP;
          end
        end

        RESP: begin
          if (!rsp_valid) begin
            // Writes and rejected accesses return zero data.
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (cap_we || acc_err) ? '0 : mem_rdata;
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0)
// compared every cycle against a transaction-level model, plus directed
// literal checks for latency, aliasing, reset abort, alignment and hold.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dut_w2 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut_w0 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  function automatic int wc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mm [2][64];
  bit          kn [2][64];
  bit          live [2];
  bit          pend [2];
  int          acc  [2];
  bit          c_we [2];
  bit          c_mis[2];
  int          c_idx[2];
  logic [31:0] c_wd [2];
  bit          exp_rr[2], exp_rv[2], exp_busy[2], exp_er[2], exp_known[2], exp_dchk[2];
  logic [31:0] exp_rd[2];
  int          edge_no = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      live[i] = 0;
      pend[i] = 0;
      for (int j = 0; j < 64; j++) kn[i][j] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        live[i] = 1; pend[i] = 0;
        exp_rr[i] = 1; exp_rv[i] = 0; exp_busy[i] = 0;
        exp_rd[i] = 0; exp_er[i] = 0; exp_dchk[i] = 1;
      end else if (live[i]) begin
        if (pend[i] && edge_no == acc[i] + 1 + wc(i)) begin
          // The one and only access of this transaction.
          if (c_we[i]) begin
            if (!c_mis[i]) begin
              mm[i][c_idx[i]] = c_wd[i];
              kn[i][c_idx[i]] = 1;
            end
            exp_rd[i] = 0; exp_known[i] = 1;
          end else begin
            exp_rd[i]    = c_mis[i] ? 32'h0 : mm[i][c_idx[i]];
            exp_known[i] = c_mis[i] || kn[i][c_idx[i]];
          end
          exp_er[i] = c_mis[i];
        end else if (pend[i] && edge_no > acc[i] + 1 + wc(i) && rsp_ready[i]) begin
          pend[i] = 0;
        end else if (!pend[i] && req_valid[i]) begin
          pend[i]  = 1;
          acc[i]   = edge_no;
          c_we[i]  = req_we[i];
          c_idx[i] = int'(req_addr[i][7:2]);
          c_mis[i] = ALIGN && (req_addr[i][1:0] != 2'b00);
          c_wd[i]  = req_wdata[i];
        end
        exp_rr[i]   = !pend[i];
        exp_busy[i] = pend[i];
        exp_rv[i]   = pend[i] && (edge_no >= acc[i] + 1 + wc(i));
        exp_dchk[i] = exp_rv[i] && exp_known[i];
      end
    end
    edge_no++;
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (live[i]) begin
        chk($sformatf("i%0d req_ready", i), 32'(req_ready[i]), 32'(exp_rr[i]));
        chk($sformatf("i%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(exp_rv[i]));
        chk($sformatf("i%0d busy", i),      32'(busy[i]),      32'(exp_busy[i]));
        if (exp_rv[i] || exp_dchk[i])
          chk($sformatf("i%0d rsp_err", i), 32'(rsp_err[i]), 32'(exp_er[i]));
        if (exp_dchk[i])
          chk($sformatf("i%0d rsp_rdata", i), rsp_rdata[i], exp_rd[i]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic txn(input int i, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output bit er, output int lat);
    bit ok;
    rd = 32'hx; er = 1'bx; lat = -1;
    @(posedge clk); #1;
    req_valid[i] = 1; req_we[i] = we; req_addr[i] = addr; req_wdata[i] = wd;
    rsp_ready[i] = (hold == 0);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL i%0d accept_timeout actual=no_accept required=accept", i);
    end
    @(posedge clk); #1;          // accept edge T has just passed
    req_valid[i] = 0;
    ok = 0;
    for (int k = 0; k < 25 && !ok; k++) begin
      @(negedge clk);            // state after edge T+k
      if (rsp_valid[i]) begin
        ok = 1; lat = k; rd = rsp_rdata[i]; er = rsp_err[i];
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL i%0d rsp_timeout actual=no_rsp required=rsp", i);
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk($sformatf("i%0d hold_valid", i), 32'(rsp_valid[i]), 32'd1);
        chk($sformatf("i%0d hold_rdata", i), rsp_rdata[i], rd);
        chk($sformatf("i%0d hold_req_ready", i), 32'(req_ready[i]), 32'd0);
      end
      rsp_ready[i] = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_drive(input int i, input int n);
    logic [31:0] a;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      a = $urandom;
      a[7:2] = 6'($urandom_range(0, 15));
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      req_valid[i] = ($urandom % 3) != 0;
      req_we[i]    = $urandom % 2;
      req_addr[i]  = a;
      req_wdata[i] = $urandom;
      rsp_ready[i] = ($urandom % 4) != 0;
      rst[i]       = ($urandom % 100) == 0;
    end
    @(posedge clk); #1;
    req_valid[i] = 0; rsp_ready[i] = 1; rst[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; req_valid[i] = 0; req_we[i] = 0; req_addr[i] = 0;
      req_wdata[i] = 0; rsp_ready[i] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 0; rst[1] = 0;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst rsp_rdata", rsp_rdata[0], 32'h0);
    chk("rst rsp_err",   32'(rsp_err[0]), 32'd0);
    chk("rst busy",      32'(busy[0]), 32'd0);

    // Write then read back, WAIT_CYCLES=2.
    txn(0, 1, 32'h54, 32'hDEADBEEF, 0, rd, er, lat);
    chk("w2 write latency", 32'(lat), 32'd3);
    chk("w2 write rdata", rd, 32'h0);
    txn(0, 0, 32'h54, 32'h0, 0, rd, er, lat);
    chk("w2 read latency", 32'(lat), 32'd3);
    chk("w2 read rdata", rd, 32'hDEADBEEF);

    // Upper address bits alias.
    txn(0, 1, 32'h000, 32'h11111111, 0, rd, er, lat);
    txn(0, 0, 32'h100, 32'h0, 0, rd, er, lat);
    chk("alias rdata", rd, 32'h11111111);

    // Reset while a write waits: no response, old data kept.
    txn(0, 1, 32'h08, 32'h01234567, 0, rd, er, lat);
    @(posedge clk); #1;
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h08; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;          // accepted
    req_valid[0] = 0;
    @(posedge clk); #1;          // in WAIT
    rst[0] = 1;
    @(posedge clk); #1;
    rst[0] = 0;
    @(negedge clk);
    chk("midrst req_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst busy", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    txn(0, 0, 32'h08, 32'h0, 0, rd, er, lat);
    chk("midrst old_data", rd, 32'h01234567);

    // Misaligned write.
    txn(0, 1, 32'h0A, 32'h55AA55AA, 0, rd, er, lat);
    chk("misalign err", 32'(er), 32'(ALIGN));
    chk("misalign wr rdata", rd, 32'h0);
    txn(0, 0, 32'h08, 32'h0, 0, rd, er, lat);
    chk("misalign word08", rd, ALIGN ? 32'h01234567 : 32'h55AA55AA);

    // WAIT_CYCLES=0 with response backpressure.
    txn(1, 1, 32'h20, 32'hA5A5A5A5, 0, rd, er, lat);
    chk("w0 write latency", 32'(lat), 32'd1);
    txn(1, 0, 32'h20, 32'h0, 3, rd, er, lat);
    chk("w0 read latency", 32'(lat), 32'd1);
    chk("w0 read rdata", rd, 32'hA5A5A5A5);

    // Randomized traffic on both instances in parallel.
    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
    join
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
